otp_decryptor: RTL and testbench



---
 rtl/otp_pkg.sv | 17 +
 rtl/otp_lfsr.sv | 16 +
 rtl/otp_decryptor.sv | 92 +++++++++
 tb/tb_otp_decryptor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/otp_pkg.sv
// otp_pkg: shared widths, LFSR constants, FSM state type and LFSR step function
package otp_pkg;
  localparam int DATA_W = 8;
  localparam int IDX_W = 4;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0] cnt_t;
  typedef logic [7:0] lfsr_t;
  typedef enum logic {FILL, RUN} state_t;
  // Fibonacci step: shift left, feedback is the parity of the tapped bits
  function automatic lfsr_t lfsr_next(input lfsr_t s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/otp_lfsr.sv
// otp_lfsr: 8-bit Fibonacci pad generator
//   clk, rst_n : clock, async active-low reset (loads LFSR_SEED)
//   adv        : step to the next state this cycle
//   q          : current LFSR state (the next pad)
module otp_lfsr
  import otp_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  adv,
  output lfsr_t q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= LFSR_SEED;
    else if (adv) q <= lfsr_next(q);
endmodule

// File: rtl/otp_decryptor.sv
// otp_decryptor: one-time-pad receiver with a 16-slot pad store refilled in ring order
//   clk, rst_n           : clock, async active-low reset
//   ena                  : freezes all state when low
//   ct_valid/ct_ready    : ciphertext handshake, ct_data byte with ct_index pad slot
//   pt_valid/pt_ready    : plaintext handshake, pt_data, pt_index echo, pt_err on pad reuse
//   pads_ready           : initial fill done
//   pads_avail           : count of unconsumed slots
//   reuse_err            : sticky pad-reuse flag
module otp_decryptor
  import otp_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  ena,
  input  logic  ct_valid,
  output logic  ct_ready,
  input  data_t ct_data,
  input  idx_t  ct_index,
  output logic  pt_valid,
  input  logic  pt_ready,
  output data_t pt_data,
  output idx_t  pt_index,
  output logic  pt_err,
  output logic  pads_ready,
  output cnt_t  pads_avail,
  output logic  reuse_err
);
  state_t state;
  idx_t fill_ptr, refill_ptr, wr_ptr;
  data_t mem [DEPTH];
  logic [DEPTH-1:0] consumed, consumed_nxt;
  lfsr_t lfsr;
  logic fill_we, refill_we, adv, accept, reuse;
  cnt_t avail_nxt;

  otp_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .adv(adv), .q(lfsr));

  assign ct_ready = (state == RUN) & ena & (~pt_valid | pt_ready);
  assign accept = ct_valid & ct_ready;
  assign reuse = consumed[ct_index];
  assign fill_we = ena & (state == FILL);
  assign refill_we = ena & (state == RUN) & consumed[refill_ptr];
  assign adv = fill_we | refill_we;
  assign wr_ptr = fill_we ? fill_ptr : refill_ptr;

  // A refill only clears a slot that is already consumed, so an accept on the
  // same slot is a reuse and never sets the bit: the two updates cannot collide.
  always_comb begin
    consumed_nxt = consumed;
    if (adv) consumed_nxt[wr_ptr] = 1'b0;
    if (accept & ~reuse) consumed_nxt[ct_index] = 1'b1;
    avail_nxt = cnt_t'(DEPTH);
    for (int i = 0; i < DEPTH; i++) avail_nxt = avail_nxt - cnt_t'(consumed_nxt[i]);
  end

  // Pad storage needs no reset: every slot is written during FILL before it can be read.
  always_ff @(posedge clk)
    if (adv) mem[wr_ptr] <= lfsr;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FILL;
      fill_ptr <= '0;
      refill_ptr <= '0;
      consumed <= '1;
      pads_ready <= 1'b0;
      pads_avail <= '0;
      pt_valid <= 1'b0;
      pt_data <= '0;
      pt_index <= '0;
      pt_err <= 1'b0;
      reuse_err <= 1'b0;
    end else begin
      consumed <= consumed_nxt;
      pads_avail <= avail_nxt;
      if (fill_we) begin
        fill_ptr <= fill_ptr + 1'b1;
        if (fill_ptr == idx_t'(DEPTH - 1)) begin
          state <= RUN;
          pads_ready <= 1'b1;
        end
      end
      if (refill_we) refill_ptr <= refill_ptr + 1'b1;
      if (accept) begin
        pt_valid <= 1'b1;
        pt_data <= reuse ? '0 : ct_data ^ mem[ct_index];
        pt_index <= ct_index;
        pt_err <= reuse;
        if (reuse) reuse_err <= 1'b1;
      end else if (ena & pt_ready) pt_valid <= 1'b0;
    end
endmodule

// File: tb/tb_otp_decryptor.sv
// tb_otp_decryptor: randomized and directed scoreboard bench for otp_decryptor
module tb_otp_decryptor;
  import otp_pkg::*;
  logic clk = 0, rst_n = 1, ena = 0, ct_valid = 0, pt_ready = 0;
  data_t ct_data = '0;
  idx_t ct_index = '0;
  logic ct_ready, pt_valid, pt_err, pads_ready, reuse_err;
  data_t pt_data;
  idx_t pt_index;
  cnt_t pads_avail;
  int vectors = 0, miscompares = 0;
  typedef struct packed {data_t d; idx_t i; logic e;} beat_t;
  beat_t sb[$];
  logic [7:0] m_lfsr;
  logic [7:0] m_pad [16];
  bit m_used [16];
  int m_fill, m_rp, m_avail;
  bit m_run, m_pv, m_reuse, m_ready;

  otp_decryptor dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .ct_data(ct_data), .ct_index(ct_index), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_data(pt_data), .pt_index(pt_index), .pt_err(pt_err), .pads_ready(pads_ready),
    .pads_avail(pads_avail), .reuse_err(reuse_err)
  );

  always #5 clk = ~clk;

  function void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  // x^8+x^6+x^5+x^4+1 written out from the polynomial
  function automatic logic [7:0] ref_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic model_reset();
    m_lfsr = 8'h01; m_fill = 0; m_rp = 0; m_run = 0; m_pv = 0; m_reuse = 0; m_ready = 0; m_avail = 0;
    foreach (m_used[k]) m_used[k] = 1;
    sb.delete();
  endtask

  task automatic model_step();
    bit acc, ru;
    int x;
    beat_t b;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (ena && !m_run) begin
      m_pad[m_fill] = m_lfsr; m_used[m_fill] = 0; m_lfsr = ref_next(m_lfsr); m_fill++;
      if (m_fill == 16) begin m_run = 1; m_ready = 1; end
    end else if (ena) begin
      x = int'(ct_index);
      acc = ct_valid && (!m_pv || pt_ready);
      ru = m_used[x];
      if (acc) begin
        b.d = ru ? 8'h00 : (ct_data ^ m_pad[x]); b.i = ct_index; b.e = ru;
        sb.push_back(b);
      end
      if (m_used[m_rp]) begin
        m_pad[m_rp] = m_lfsr; m_used[m_rp] = 0; m_lfsr = ref_next(m_lfsr); m_rp = (m_rp + 1) % 16;
      end
      if (acc && !ru) m_used[x] = 1;
      if (acc) begin m_pv = 1; if (ru) m_reuse = 1; end
      else if (pt_ready) m_pv = 0;
    end
    m_avail = 0;
    foreach (m_used[k]) if (!m_used[k]) m_avail++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input data_t d, input idx_t i);
    ct_valid = 1; ct_data = d; ct_index = i;
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ct_ready"}, ct_ready, 0);
    chk({tag, "_pt_valid"}, pt_valid, 0);
    chk({tag, "_pt_data"}, pt_data, 0);
    chk({tag, "_pt_index"}, pt_index, 0);
    chk({tag, "_pt_err"}, pt_err, 0);
    chk({tag, "_pads_ready"}, pads_ready, 0);
    chk({tag, "_pads_avail"}, pads_avail, 0);
    chk({tag, "_reuse_err"}, reuse_err, 0);
  endtask

  task automatic drain();
    ct_valid = 0; pt_ready = 1; ena = 1;
    repeat (4) tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d beats outstanding, required 0", sb.size());
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("ct_ready", ct_ready, m_run && ena && (!m_pv || pt_ready));
    chk("pads_avail", pads_avail, m_avail);
    chk("pads_ready", pads_ready, m_ready);
    chk("reuse_err", reuse_err, m_reuse);
    chk("pt_valid", pt_valid, m_pv);
    if (pt_valid) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_beat: pt_data %0h with nothing expected", pt_data);
      end else begin
        chk("pt_data", pt_data, sb[0].d);
        chk("pt_index", pt_index, sb[0].i);
        chk("pt_err", pt_err, sb[0].e);
        if (pt_ready && ena) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded its time budget");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1 rst_n = 0;
    #2 check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1; ena = 1;
    repeat (5) tick();
    ena = 0;
    repeat (4) tick();
    ena = 1;
    repeat (40) if (!m_run) tick();
    pt_ready = 1;
    send(8'hAB, 4'd0);
    send(8'h08, 4'd3);
    send(8'h00, 4'd4);
    ct_valid = 0;
    repeat (2) tick();
    pt_ready = 0;
    send(8'h5A, 4'd7);
    ct_data = 8'h33; ct_index = 4'd9;
    repeat (5) tick();
    pt_ready = 1;
    tick();
    ct_valid = 0;
    tick();
    send(8'h12, 4'd5);
    send(8'h34, 4'd5);
    ct_valid = 0;
    repeat (2) tick();
    send(8'h00, 4'd1);
    ct_valid = 0;
    tick();
    send(8'h00, 4'd1);
    ct_valid = 0;
    tick();
    for (int n = 0; n < 400; n++) begin
      ena = ($urandom_range(9) != 0);
      ct_valid = $urandom_range(1);
      ct_data = data_t'($urandom);
      ct_index = idx_t'($urandom);
      pt_ready = ($urandom_range(3) != 0);
      tick();
    end
    drain();
    pt_ready = 0;
    send(8'hC3, idx_t'(m_rp));
    ct_valid = 0;
    rst_n = 0;
    #1 check_zero("midrun_reset");
    model_reset();
    repeat (2) tick();
    rst_n = 1; ena = 1;
    repeat (20) tick();
    for (int n = 0; n < 100; n++) begin
      ct_valid = $urandom_range(1);
      ct_data = data_t'($urandom);
      ct_index = idx_t'($urandom_range(3));
      pt_ready = $urandom_range(1);
      tick();
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
